// File: rtl/booth_mac_seq_if.sv
// ---------------------------------------------------------------------------
// booth_mac_seq_if
// Handshake bundle for the sequential Booth multiply-accumulate unit.
//   in_valid/in_ready   : operand-side handshake (source -> MAC)
//   a, b, mode          : signed operands and per-op accumulate select
//   acc_clr             : single-cycle accumulator/overflow clear pulse
//   out_valid/out_ready : result-side handshake (MAC -> consumer)
//   result, overflow    : accumulator contents and sticky overflow flag
// master = operand source / result consumer, slave = the MAC itself.
// ---------------------------------------------------------------------------
interface booth_mac_seq_if #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [WIDTH-1:0]     a;
    logic signed [WIDTH-1:0]     b;
    logic                        mode;
    logic                        acc_clr;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] result;
    logic                        overflow;

    modport master (
        output in_valid, a, b, mode, acc_clr, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    modport slave (
        input  in_valid, a, b, mode, acc_clr, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/booth_mac_seq.sv
// ---------------------------------------------------------------------------
// booth_mac_seq
// Sequential radix-2 Booth multiply-accumulate, one operation at a time.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : booth_mac_seq_if.slave (operand/result handshakes, mode,
//           acc_clr, result, overflow)
// Flow: IDLE (accept) -> CALC (WIDTH Booth steps) -> ACC (add/saturate)
//       -> DONE (hold result until out_ready).
// ---------------------------------------------------------------------------
module booth_mac_seq #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int SATURATE  = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    booth_mac_seq_if.slave bus
);
    localparam int PW = 2 * WIDTH + 2;
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, CALC, ACC, DONE} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic signed [WIDTH-1:0]     r_a;
    logic                        r_mode;
    logic        [PW-1:0]        r_p;
    logic        [CW-1:0]        r_cnt;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic                        r_ovf;

    logic                        w_in_ready;
    logic                        w_out_valid;
    logic                        w_accept;
    logic signed [WIDTH:0]       w_upper;
    logic signed [WIDTH:0]       w_a_ext;
    logic signed [WIDTH:0]       w_upper_sum;
    logic        [PW-1:0]        w_p_shift;
    logic signed [2*WIDTH-1:0]   w_prod;
    logic signed [ACC_WIDTH:0]   w_base;
    logic signed [ACC_WIDTH:0]   w_sum;
    logic                        w_ovf;

    // Clamp (or wrap) the one-bit-wider sum back to ACC_WIDTH bits.
    function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
        input logic signed [ACC_WIDTH:0] s
    );
        logic ovf;
        ovf = s[ACC_WIDTH] ^ s[ACC_WIDTH-1];
        if (ovf && (SATURATE != 0)) begin
            if (s[ACC_WIDTH])
                sat_acc = {1'b1, {(ACC_WIDTH-1){1'b0}}};
            else
                sat_acc = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            sat_acc = s[ACC_WIDTH-1:0];
        end
    endfunction

    // Booth step: the upper field is WIDTH+1 bits so subtracting the most
    // negative multiplicand cannot overflow.
    always_comb begin
        w_upper = r_p[PW-1:WIDTH+1];
        w_a_ext = {r_a[WIDTH-1], r_a};
        case (r_p[1:0])
            2'b01:   w_upper_sum = w_upper + w_a_ext;
            2'b10:   w_upper_sum = w_upper - w_a_ext;
            default: w_upper_sum = w_upper;
        endcase
        w_p_shift = {w_upper_sum[WIDTH], w_upper_sum, r_p[WIDTH:1]};
    end

    // Accumulate: a coincident clear drops the old accumulator, so the
    // stored value is the bare product and cannot overflow.
    always_comb begin
        w_prod = r_p[2*WIDTH:1];
        w_base = (r_mode && !bus.acc_clr) ? (ACC_WIDTH+1)'(r_acc) : '0;
        w_sum  = w_base + (ACC_WIDTH+1)'(w_prod);
        w_ovf  = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // FSM next state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) w_state_nxt = CALC;
            end
            CALC: if (r_cnt == '0) w_state_nxt = ACC;
            ACC:  w_state_nxt = DONE;
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept      = w_in_ready && bus.in_valid;
    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.result    = r_acc;
    assign bus.overflow  = r_ovf;

    // Operand capture and Booth shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_mode <= 1'b0;
            r_p    <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a    <= bus.a;
            r_mode <= bus.mode;
            r_p    <= {{(WIDTH+1){1'b0}}, bus.b, 1'b0};
            r_cnt  <= CW'(WIDTH - 1);
        end else if (r_state == CALC) begin
            r_p <= w_p_shift;
            if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        end
    end

    // Accumulator and sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (r_state == ACC) begin
            r_acc <= sat_acc(w_sum);
            r_ovf <= (r_ovf && !bus.acc_clr) || w_ovf;
        end else if (bus.acc_clr) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_booth_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mac_seq
// Directed bench for booth_mac_seq: a 16x16/40-bit saturating instance for
// the main scenarios, plus a pair of 16x16/32-bit instances (saturating and
// wrapping) driven by identical stimulus for the overflow scenarios.
// ---------------------------------------------------------------------------
module tb_booth_mac_seq;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    booth_mac_seq_if #(.WIDTH(16), .ACC_WIDTH(40)) if0 ();
    booth_mac_seq_if #(.WIDTH(16), .ACC_WIDTH(32)) ifs ();
    booth_mac_seq_if #(.WIDTH(16), .ACC_WIDTH(32)) ifw ();

    logic               s_in_valid;
    logic signed [15:0] s_a;
    logic signed [15:0] s_b;
    logic               s_mode;
    logic               s_acc_clr;
    logic               s_out_ready;

    assign ifs.in_valid  = s_in_valid;
    assign ifs.a         = s_a;
    assign ifs.b         = s_b;
    assign ifs.mode      = s_mode;
    assign ifs.acc_clr   = s_acc_clr;
    assign ifs.out_ready = s_out_ready;
    assign ifw.in_valid  = s_in_valid;
    assign ifw.a         = s_a;
    assign ifw.b         = s_b;
    assign ifw.mode      = s_mode;
    assign ifw.acc_clr   = s_acc_clr;
    assign ifw.out_ready = s_out_ready;

    booth_mac_seq #(.WIDTH(16), .ACC_WIDTH(40), .SATURATE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(if0.slave));
    booth_mac_seq #(.WIDTH(16), .ACC_WIDTH(32), .SATURATE(1)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(ifs.slave));
    booth_mac_seq #(.WIDTH(16), .ACC_WIDTH(32), .SATURATE(0)) u_wrap (
        .clk(clk), .rst_n(rst_n), .bus(ifw.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op on the 40-bit DUT, wait (bounded) for out_valid, capture
    // the result and complete the output handshake.
    task automatic run_op(input logic signed [15:0] ta, input logic signed [15:0] tb_,
                          input logic tm, output logic [39:0] res, output logic ov,
                          output int lat);
        @(negedge clk);
        if0.a = ta; if0.b = tb_; if0.mode = tm; if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        lat = 0;
        while (!if0.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        res = if0.result;
        ov  = if0.overflow;
        @(negedge clk); if0.out_ready = 1'b1;
        @(posedge clk); #1; if0.out_ready = 1'b0;
    endtask

    // Same for the 32-bit pair (they run in lockstep).
    task automatic run_op_s(input logic signed [15:0] ta, input logic signed [15:0] tb_,
                            input logic tm, output logic [31:0] rs, output logic os,
                            output logic [31:0] rw, output logic ow);
        int lat;
        @(negedge clk);
        s_a = ta; s_b = tb_; s_mode = tm; s_in_valid = 1'b1;
        @(posedge clk); #1;
        s_in_valid = 1'b0;
        lat = 0;
        while (!ifs.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        rs = ifs.result; os = ifs.overflow;
        rw = ifw.result; ow = ifw.overflow;
        @(negedge clk); s_out_ready = 1'b1;
        @(posedge clk); #1; s_out_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk); if0.acc_clr = 1'b1; s_acc_clr = 1'b1;
        @(posedge clk); #1; if0.acc_clr = 1'b0; s_acc_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if0.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", if0.in_ready); end
        checks++; if (if0.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", if0.out_valid); end
        checks++; if (if0.result !== 40'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", if0.result); end
        checks++; if (if0.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", if0.overflow); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_multiply();
        logic [39:0] res; logic ov; int lat;
        run_op(16'sd3, -16'sd5, 1'b0, res, ov, lat);
        checks++; if (res !== 40'hFF_FFFF_FFF1) begin errors++; $display("FAIL mul_3x-5: got %h expected ff_ffff_fff1", res); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL latency: got %0d expected 17", lat); end
        checks++; if (ov !== 1'b0) begin errors++; $display("FAIL mul_overflow: got %b expected 0", ov); end
        run_op(-16'sd32768, -16'sd32768, 1'b0, res, ov, lat);
        checks++; if (res !== 40'h00_4000_0000) begin errors++; $display("FAIL mul_minxmin: got %h expected 00_4000_0000", res); end
        run_op(-16'sd32768, 16'sd1, 1'b0, res, ov, lat);
        checks++; if (res !== 40'hFF_FFFF_8000) begin errors++; $display("FAIL mul_minx1: got %h expected ff_ffff_8000", res); end
        run_op(16'sd32767, -16'sd32768, 1'b0, res, ov, lat);
        checks++; if (res !== 40'hFF_C000_8000) begin errors++; $display("FAIL mul_maxxmin: got %h expected ff_c000_8000", res); end
    endtask

    task automatic test_accumulate();
        logic [39:0] res; logic ov; int lat;
        pulse_clr();
        run_op(16'sd100, 16'sd200, 1'b1, res, ov, lat);
        checks++; if (res !== 40'd20000) begin errors++; $display("FAIL acc_1: got %0d expected 20000", $signed(res)); end
        run_op(-16'sd50, 16'sd4, 1'b1, res, ov, lat);
        checks++; if (res !== 40'd19800) begin errors++; $display("FAIL acc_2: got %0d expected 19800", $signed(res)); end
        run_op(16'sd7, -16'sd7, 1'b1, res, ov, lat);
        checks++; if (res !== 40'd19751) begin errors++; $display("FAIL acc_3: got %0d expected 19751", $signed(res)); end
        run_op(16'sd2, 16'sd2, 1'b0, res, ov, lat);
        checks++; if (res !== 40'd4) begin errors++; $display("FAIL acc_mode0: got %0d expected 4", $signed(res)); end
    endtask

    task automatic test_acc_clr();
        logic [39:0] res; logic ov; int lat;
        // Clear on the ACC edge: acc holds 4, op 3*3 accumulate -> 9, not 13.
        @(negedge clk);
        if0.a = 16'sd3; if0.b = 16'sd3; if0.mode = 1'b1; if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        repeat (16) @(posedge clk);
        @(negedge clk); if0.acc_clr = 1'b1;
        @(posedge clk); #1; if0.acc_clr = 1'b0;
        checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL clr_acc_edge_valid: got %b expected 1", if0.out_valid); end
        checks++; if (if0.result !== 40'd9) begin errors++; $display("FAIL clr_acc_edge_result: got %0d expected 9", $signed(if0.result)); end
        @(negedge clk); if0.out_ready = 1'b1;
        @(posedge clk); #1; if0.out_ready = 1'b0;
        // Clear while holding in DONE.
        @(negedge clk);
        if0.a = 16'sd5; if0.b = 16'sd5; if0.mode = 1'b1; if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        lat = 0;
        while (!if0.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++; if (if0.result !== 40'd34) begin errors++; $display("FAIL clr_done_pre: got %0d expected 34", $signed(if0.result)); end
        pulse_clr();
        checks++; if (if0.result !== 40'd0) begin errors++; $display("FAIL clr_done_result: got %0d expected 0", $signed(if0.result)); end
        checks++; if (if0.out_valid !== 1'b1) begin errors++; $display("FAIL clr_done_valid: got %b expected 1", if0.out_valid); end
        @(negedge clk); if0.out_ready = 1'b1;
        @(posedge clk); #1; if0.out_ready = 1'b0;
        res = 40'h0; ov = 1'b0;
        run_op(16'sd6, 16'sd7, 1'b1, res, ov, lat);
        checks++; if (res !== 40'd42) begin errors++; $display("FAIL clr_then_acc: got %0d expected 42", $signed(res)); end
    endtask

    task automatic test_saturation();
        logic [31:0] rs, rw; logic os, ow;
        pulse_clr();
        run_op_s(-16'sd32768, -16'sd32768, 1'b1, rs, os, rw, ow);
        checks++; if (rs !== 32'h4000_0000) begin errors++; $display("FAIL sat_first: got %h expected 4000_0000", rs); end
        checks++; if (os !== 1'b0) begin errors++; $display("FAIL sat_first_ovf: got %b expected 0", os); end
        run_op_s(-16'sd32768, -16'sd32768, 1'b1, rs, os, rw, ow);
        checks++; if (rs !== 32'h7FFF_FFFF) begin errors++; $display("FAIL sat_clamp: got %h expected 7fff_ffff", rs); end
        checks++; if (os !== 1'b1) begin errors++; $display("FAIL sat_ovf: got %b expected 1", os); end
        checks++; if (rw !== 32'h8000_0000) begin errors++; $display("FAIL wrap_value: got %h expected 8000_0000", rw); end
        checks++; if (ow !== 1'b1) begin errors++; $display("FAIL wrap_ovf: got %b expected 1", ow); end
        // Sticky: a small further accumulate keeps overflow set.
        run_op_s(16'sd1, 16'sd1, 1'b1, rs, os, rw, ow);
        checks++; if (os !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b expected 1", os); end
        checks++; if (rw !== 32'h8000_0001) begin errors++; $display("FAIL wrap_next: got %h expected 8000_0001", rw); end
        pulse_clr();
        checks++; if (ifs.result !== 32'h0 || ifs.overflow !== 1'b0) begin errors++; $display("FAIL sat_clear: got %h/%b expected 0/0", ifs.result, ifs.overflow); end
        checks++; if (ifw.result !== 32'h0 || ifw.overflow !== 1'b0) begin errors++; $display("FAIL wrap_clear: got %h/%b expected 0/0", ifw.result, ifw.overflow); end
    endtask

    task automatic test_backpressure();
        int lat;
        @(negedge clk);
        if0.a = 16'sd10; if0.b = 16'sd10; if0.mode = 1'b0; if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        lat = 0;
        while (!if0.out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if0.in_valid = ~if0.in_valid;
            if0.a = 16'(i * 1111 + 7);
            if0.b = 16'(-(i + 3));
            @(posedge clk); #1;
            checks++; if (if0.out_valid !== 1'b1 || if0.result !== 40'd100 || if0.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: got valid=%b result=%0d in_ready=%b expected 1/100/0",
                         i, if0.out_valid, $signed(if0.result), if0.in_ready);
            end
        end
        @(negedge clk); if0.in_valid = 1'b0; if0.out_ready = 1'b1;
        @(posedge clk); #1; if0.out_ready = 1'b0;
        checks++; if (if0.in_ready !== 1'b1 || if0.out_valid !== 1'b0) begin errors++; $display("FAIL release: got in_ready=%b valid=%b expected 1/0", if0.in_ready, if0.out_valid); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (if0.in_ready !== 1'b1 || if0.result !== 40'd100) begin errors++; $display("FAIL no_new_op: got in_ready=%b result=%0d expected 1/100", if0.in_ready, $signed(if0.result)); end
    endtask

    task automatic test_reset_mid();
        logic [39:0] res; logic ov; int lat;
        @(negedge clk);
        if0.a = 16'sd1000; if0.b = 16'sd1000; if0.mode = 1'b1; if0.in_valid = 1'b1;
        @(posedge clk); #1;
        if0.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (if0.out_valid !== 1'b0 || if0.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_hs: got valid=%b in_ready=%b expected 0/1", if0.out_valid, if0.in_ready); end
        checks++; if (if0.result !== 40'd0 || if0.overflow !== 1'b0) begin errors++; $display("FAIL midrst_data: got %h/%b expected 0/0", if0.result, if0.overflow); end
        @(negedge clk); rst_n = 1'b1;
        run_op(16'sd12, -16'sd12, 1'b1, res, ov, lat);
        checks++; if (res !== -40'sd144) begin errors++; $display("FAIL post_rst_op: got %0d expected -144", $signed(res)); end
        checks++; if (lat !== 17) begin errors++; $display("FAIL post_rst_latency: got %0d expected 17", lat); end
    endtask

    initial begin
        errors = 0; checks = 0;
        rst_n = 1'b0;
        if0.in_valid = 1'b0; if0.a = '0; if0.b = '0; if0.mode = 1'b0;
        if0.acc_clr = 1'b0; if0.out_ready = 1'b0;
        s_in_valid = 1'b0; s_a = '0; s_b = '0; s_mode = 1'b0;
        s_acc_clr = 1'b0; s_out_ready = 1'b0;
        test_reset();
        test_multiply();
        test_accumulate();
        test_acc_clr();
        test_saturation();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
